// File: rtl/sdr_arb_pkg.sv
// Shared encodings for the SDRAM port arbiter: FSM states, owner indices and burst op codes.
package sdr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_VID = 1'b1;

endpackage

// File: rtl/sdr_port_arbiter_if.sv
// One burst requester port of the SDRAM port arbiter (CPU cache or video prefetch).
// Handshake: rd/wr is a level request held with a stable addr until done pulses; each get
// strobe delivers one read word on dout, each put strobe consumes one write word from din.
interface sdr_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic [AW-1:0] addr;
  logic          rd;
  logic          wr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          get;
  logic          put;
  logic          done;

  modport master (
    output addr, rd, wr, din,
    input  dout, get, put, done
  );

  modport slave (
    input  addr, rd, wr, din,
    output dout, get, put, done
  );
endinterface

// File: rtl/sdr_arb_beat_cnt.sv
// Beat counter and burst watchdog for the arbiter; both restart in ISSUE and run during XFER.
module sdr_arb_beat_cnt #(
  parameter int BURST_LEN = 8,
  parameter int TMO_CYC   = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic active_i,
  input  logic beat_i,
  output logic last_o,
  output logic timeout_o
);
  localparam int BW = $clog2(BURST_LEN);
  localparam int WW = $clog2(TMO_CYC + 1);

  logic [BW-1:0] beat_q, beat_d;
  logic [WW-1:0] wd_q, wd_d;

  // The watchdog loads 1 in ISSUE so that wd_q equals cycles elapsed since ISSUE.
  always_comb begin
    beat_d = beat_q;
    wd_d   = wd_q;
    if (clr_i) begin
      beat_d = '0;
      wd_d   = WW'(1);
    end else if (active_i) begin
      wd_d = wd_q + 1'b1;
      if (beat_i) beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_q <= '0;
      wd_q   <= '0;
    end else begin
      beat_q <= beat_d;
      wd_q   <= wd_d;
    end
  end

  assign last_o    = active_i && beat_i && (beat_q == BW'(BURST_LEN - 1));
  assign timeout_o = active_i && (wd_q == WW'(TMO_CYC - 1));

endmodule

// File: rtl/sdr_port_arbiter.sv
// Shares the SDRAM controller's cache-side burst port between the CPU cache (m0) and video (m1).
// Optional ARB_STARVE_GUARD_EN: after STARVE_MAX back-to-back video grants with m0 waiting, m0 wins.
module sdr_port_arbiter
  import sdr_arb_pkg::*;
#(
  parameter int AW         = 12,
  parameter int DW         = 16,
  parameter int BURST_LEN  = 8,
  parameter int TMO_CYC    = 1024,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  sdr_port_arbiter_if.slave   m0,
  sdr_port_arbiter_if.slave   m1,
  output logic [AW-1:0]       sdr_addr_o,
  output logic                sdr_rd_o,
  output logic                sdr_wr_o,
  output logic [DW-1:0]       sdr_dout_o,
  input  logic [DW-1:0]       sdr_din_i,
  input  logic                sdr_get_i,
  input  logic                sdr_put_i,
  output logic                busy_o,
  output logic                err_o,
  output state_e              state_o
);

  if (BURST_LEN < 2 || TMO_CYC < 2 || STARVE_MAX < 1) begin : g_param_check
    $error("sdr_port_arbiter: BURST_LEN, TMO_CYC must be >= 2 and STARVE_MAX >= 1");
  end

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  op_e           op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_q, err_d;

  logic m0_req, m1_req, grant_vid;
  logic is_issue, is_xfer, is_gap;
  logic beat, last, timeout;

  assign m0_req = m0.rd || m0.wr;
  assign m1_req = m1.rd || m1.wr;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;

  // Counter stops at STARVE_MAX because the next grant with m0 waiting goes to m0 and clears it.
  always_comb begin
    starve_d  = starve_q;
    grant_vid = m1_req && !(m0_req && (starve_q == SW'(STARVE_MAX)));
    if (state_q == ST_IDLE && (m0_req || m1_req)) begin
      if (grant_vid && m0_req) starve_d = starve_q + 1'b1;
      else                     starve_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end
`else
  assign grant_vid = m1_req;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = op_q;
    addr_d  = addr_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          owner_d = grant_vid ? M_VID : M_CPU;
          op_d    = (grant_vid ? m1.rd : m0.rd) ? OP_RD : OP_WR;
          addr_d  = grant_vid ? m1.addr : m0.addr;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_XFER;
      ST_XFER: begin
        if (last) begin
          state_d = ST_GAP;
        end else if (timeout) begin
          state_d = ST_GAP;
          err_d   = 1'b1;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= M_CPU;
      op_q    <= OP_RD;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign is_issue = (state_q == ST_ISSUE);
  assign is_xfer  = (state_q == ST_XFER);
  assign is_gap   = (state_q == ST_GAP);

  // Only the strobe matching the current op advances the burst.
  assign beat = (op_q == OP_RD) ? sdr_get_i : sdr_put_i;

  sdr_arb_beat_cnt #(
    .BURST_LEN (BURST_LEN),
    .TMO_CYC   (TMO_CYC)
  ) u_beat_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (is_issue),
    .active_i  (is_xfer),
    .beat_i    (beat),
    .last_o    (last),
    .timeout_o (timeout)
  );

  assign m0.dout = sdr_din_i;
  assign m1.dout = sdr_din_i;
  assign m0.get  = is_xfer && (owner_q == M_CPU) && sdr_get_i;
  assign m0.put  = is_xfer && (owner_q == M_CPU) && sdr_put_i;
  assign m1.get  = is_xfer && (owner_q == M_VID) && sdr_get_i;
  assign m1.put  = is_xfer && (owner_q == M_VID) && sdr_put_i;
  assign m0.done = is_gap && (owner_q == M_CPU);
  assign m1.done = is_gap && (owner_q == M_VID);

  assign sdr_rd_o   = is_issue && (op_q == OP_RD);
  assign sdr_wr_o   = is_issue && (op_q == OP_WR);
  assign busy_o     = is_issue || is_xfer;
  assign sdr_addr_o = busy_o ? addr_q : '0;
  assign sdr_dout_o = is_xfer ? ((owner_q == M_VID) ? m1.din : m0.din) : '0;
  assign err_o      = err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// Directed bench for sdr_port_arbiter: reset, read, write, collision, starvation, watchdog, mid-burst reset.
module tb_sdr_port_arbiter;
  import sdr_arb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int BL = 8;
  localparam int TMO = 16;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] sdr_addr;
  logic          sdr_rd, sdr_wr;
  logic [DW-1:0] sdr_dout;
  logic [DW-1:0] sdr_din = '0;
  logic          sdr_get = 1'b0;
  logic          sdr_put = 1'b0;
  logic          busy, err;
  state_e        state;

  int n_tests = 0;
  int n_fail  = 0;

  sdr_port_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  sdr_port_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

  sdr_port_arbiter #(
    .AW(AW), .DW(DW), .BURST_LEN(BL), .TMO_CYC(TMO), .STARVE_MAX(SMAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m0         (m0_if.slave),
    .m1         (m1_if.slave),
    .sdr_addr_o (sdr_addr),
    .sdr_rd_o   (sdr_rd),
    .sdr_wr_o   (sdr_wr),
    .sdr_dout_o (sdr_dout),
    .sdr_din_i  (sdr_din),
    .sdr_get_i  (sdr_get),
    .sdr_put_i  (sdr_put),
    .busy_o     (busy),
    .err_o      (err),
    .state_o    (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_if.rd = 1'b0; m0_if.wr = 1'b0; m0_if.addr = '0; m0_if.din = '0;
    m1_if.rd = 1'b0; m1_if.wr = 1'b0; m1_if.addr = '0; m1_if.din = '0;
    sdr_get = 1'b0; sdr_put = 1'b0; sdr_din = '0;
  endtask

  task automatic drive_beats(input int n, input bit use_get, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      sdr_get = use_get;
      sdr_put = !use_get;
      sdr_din = base + DW'(i);
      m0_if.din = base + DW'(i);
      m1_if.din = base + DW'(i);
      step();
    end
    sdr_get = 1'b0;
    sdr_put = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    m0_if.rd = 1'b1; m0_if.addr = 12'h3FF;
    m0_if.din = 16'h1234; m1_if.din = 16'h5678;
    sdr_din = 16'hABCD; sdr_get = 1'b1; sdr_put = 1'b1;
    step(); step();
    @(negedge clk);
    n_tests++;
    if ({sdr_rd, sdr_wr, busy, err, m0_if.get, m0_if.put, m0_if.done, m1_if.get, m1_if.put, m1_if.done} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got rd%b wr%b busy%b err%b m0 %b%b%b m1 %b%b%b, want all 0", sdr_rd, sdr_wr, busy, err,
               m0_if.get, m0_if.put, m0_if.done, m1_if.get, m1_if.put, m1_if.done);
    end
    n_tests++;
    if (state !== ST_IDLE || sdr_addr !== '0 || sdr_dout !== '0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d addr=%h dout=%h, want IDLE 000 0000", state, sdr_addr, sdr_dout);
    end
    n_tests++;
    if (m0_if.dout !== 16'hABCD || m1_if.dout !== 16'hABCD) begin
      n_fail++;
      $display("FAIL reset_dout: m0=%h m1=%h, want abcd", m0_if.dout, m1_if.dout);
    end
    idle_inputs();
    rst = 1'b1;
    step();
  endtask

  task automatic test_m0_read();
    logic [DW-1:0] exp_d;
    m0_if.rd = 1'b1; m0_if.addr = 12'h0A5;
    @(negedge clk);
    n_tests++;
    if (state !== ST_IDLE || sdr_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_latency: state=%0d sdr_rd=%b in request cycle, want IDLE 0", state, sdr_rd);
    end
    step();
    @(negedge clk);
    n_tests++;
    if ({sdr_rd, sdr_wr, busy} !== 3'b101 || sdr_addr !== 12'h0A5) begin
      n_fail++;
      $display("FAIL rd_issue: rd%b wr%b busy%b addr=%h, want 1 0 1 0a5", sdr_rd, sdr_wr, busy, sdr_addr);
    end
    step();
    for (int i = 0; i < BL; i++) begin
      sdr_get = 1'b1;
      exp_d = 16'hD000 + DW'(i);
      sdr_din = exp_d;
      @(negedge clk);
      n_tests++;
      if ({m0_if.get, m1_if.get, m0_if.done} !== 3'b100 || m0_if.dout !== exp_d || sdr_addr !== 12'h0A5) begin
        n_fail++;
        $display("FAIL rd_beat%0d: m0_get%b m1_get%b done%b dout=%h addr=%h, want 1 0 0 %h 0a5", i,
                 m0_if.get, m1_if.get, m0_if.done, m0_if.dout, sdr_addr, exp_d);
      end
      step();
    end
    sdr_get = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({m0_if.done, m1_if.done, sdr_rd, busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rd_done: m0_done%b m1_done%b rd%b busy%b, want 1 0 0 0", m0_if.done, m1_if.done, sdr_rd, busy);
    end
    step();
    @(negedge clk);
    n_tests++;
    if ({m0_if.done, sdr_rd} !== 2'b00 || state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL rd_gap: done%b rd%b state=%0d, want 0 0 IDLE", m0_if.done, sdr_rd, state);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (sdr_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_reissue: sdr_rd=%b two cycles after done, want 1", sdr_rd);
    end
    m0_if.rd = 1'b0;
    step();
    drive_beats(BL, 1'b1, 16'h0);
    @(negedge clk);
    n_tests++;
    if (m0_if.done !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_second_done: m0_done=%b, want 1", m0_if.done);
    end
    step();
  endtask

  task automatic test_m0_write();
    logic [DW-1:0] exp_d;
    m0_if.wr = 1'b1; m0_if.addr = 12'h123;
    step();
    @(negedge clk);
    n_tests++;
    if ({sdr_wr, sdr_rd, busy} !== 3'b101 || sdr_addr !== 12'h123) begin
      n_fail++;
      $display("FAIL wr_issue: wr%b rd%b busy%b addr=%h, want 1 0 1 123", sdr_wr, sdr_rd, busy, sdr_addr);
    end
    step();
    for (int i = 0; i < BL; i++) begin
      if (i == 4) begin
        sdr_put = 1'b0; sdr_get = 1'b1;
        @(negedge clk);
        n_tests++;
        if (state !== ST_XFER || m0_if.done !== 1'b0) begin
          n_fail++;
          $display("FAIL wr_stray_get: state=%0d done=%b, want XFER 0", state, m0_if.done);
        end
        step();
      end
      sdr_get = 1'b0; sdr_put = 1'b1;
      exp_d = DW'(i);
      m0_if.din = exp_d;
      @(negedge clk);
      n_tests++;
      if (sdr_dout !== exp_d || m0_if.put !== 1'b1 || state !== ST_XFER) begin
        n_fail++;
        $display("FAIL wr_beat%0d: sdr_dout=%h put=%b state=%0d, want %h 1 XFER", i, sdr_dout, m0_if.put, state, exp_d);
      end
      step();
    end
    sdr_put = 1'b0;
    @(negedge clk);
    n_tests++;
    if (m0_if.done !== 1'b1 || state !== ST_GAP) begin
      n_fail++;
      $display("FAIL wr_done: done=%b state=%0d, want 1 GAP", m0_if.done, state);
    end
    m0_if.wr = 1'b0;
    step();
  endtask

  task automatic test_collision();
    m0_if.rd = 1'b1; m0_if.addr = 12'h111;
    m1_if.rd = 1'b1; m1_if.addr = 12'h222;
    step();
    @(negedge clk);
    n_tests++;
    if (sdr_addr !== 12'h222 || sdr_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL col_first_grant: addr=%h rd=%b, want 222 1", sdr_addr, sdr_rd);
    end
    step();
    for (int i = 0; i < BL; i++) begin
      sdr_get = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({m1_if.get, m0_if.get} !== 2'b10) begin
        n_fail++;
        $display("FAIL col_routing%0d: m1_get%b m0_get%b, want 1 0", i, m1_if.get, m0_if.get);
      end
      step();
    end
    sdr_get = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({m1_if.done, m0_if.done} !== 2'b10) begin
      n_fail++;
      $display("FAIL col_done_m1: m1_done%b m0_done%b, want 1 0", m1_if.done, m0_if.done);
    end
    m1_if.rd = 1'b0;
    step();
    step();
    @(negedge clk);
    n_tests++;
    if (sdr_addr !== 12'h111 || sdr_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL col_second_grant: addr=%h rd=%b, want 111 1", sdr_addr, sdr_rd);
    end
    step();
    drive_beats(BL, 1'b1, 16'h0100);
    @(negedge clk);
    n_tests++;
    if ({m1_if.done, m0_if.done} !== 2'b01) begin
      n_fail++;
      $display("FAIL col_done_m0: m1_done%b m0_done%b, want 0 1", m1_if.done, m0_if.done);
    end
    m0_if.rd = 1'b0;
    step();
    @(negedge clk);
    n_tests++;
    if ({m1_if.done, m0_if.done} !== 2'b00 || state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL col_single_pulse: m1_done%b m0_done%b state=%0d, want 0 0 IDLE", m1_if.done, m0_if.done, state);
    end
  endtask

  task automatic test_starve();
    bit            exp_vid;
    logic [AW-1:0] exp_a;
    m1_if.rd = 1'b1; m1_if.addr = 12'h2A0;
    m0_if.rd = 1'b1; m0_if.addr = 12'h0B0;
    for (int b = 0; b < SMAX + 1; b++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_vid = (b < SMAX);
`else
      exp_vid = 1'b1;
`endif
      exp_a = exp_vid ? 12'h2A0 : 12'h0B0;
      step();
      @(negedge clk);
      n_tests++;
      if (sdr_addr !== exp_a) begin
        n_fail++;
        $display("FAIL starve_grant%0d: addr=%h, want %h", b, sdr_addr, exp_a);
      end
      step();
      drive_beats(BL, 1'b1, 16'h0200);
      @(negedge clk);
      n_tests++;
      if ({m1_if.done, m0_if.done} !== {exp_vid, !exp_vid}) begin
        n_fail++;
        $display("FAIL starve_done%0d: m1_done%b m0_done%b, want %b %b", b, m1_if.done, m0_if.done, exp_vid, !exp_vid);
      end
      step();
    end
    m0_if.rd = 1'b0;
    m1_if.rd = 1'b0;
    step();
  endtask

  task automatic test_watchdog();
    bit early;
    m0_if.rd = 1'b1; m0_if.addr = 12'h03C;
    step();
    @(negedge clk);
    n_tests++;
    if (sdr_rd !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_issue: rd=%b err=%b, want 1 0", sdr_rd, err);
    end
    step();
    drive_beats(3, 1'b1, 16'h0300);
    early = 1'b0;
    for (int k = 4; k < TMO; k++) begin
      @(negedge clk);
      if (state !== ST_XFER || m0_if.done !== 1'b0 || err !== 1'b0) early = 1'b1;
      step();
    end
    n_tests++;
    if (early) begin
      n_fail++;
      $display("FAIL wd_early: burst ended before grant+%0d (early=%b), want 0", TMO, early);
    end
    @(negedge clk);
    n_tests++;
    if ({m0_if.done, err} !== 2'b11 || state !== ST_GAP) begin
      n_fail++;
      $display("FAIL wd_abort: done%b err%b state=%0d at grant+%0d, want 1 1 GAP", m0_if.done, err, state, TMO);
    end
    m0_if.rd = 1'b0;
    step();
    @(negedge clk);
    n_tests++;
    if (state !== ST_IDLE || err !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_idle: state=%0d err=%b, want IDLE 1", state, err);
    end
    step(); step(); step();
    @(negedge clk);
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_sticky: err=%b, want 1", err);
    end
  endtask

  task automatic test_reset_mid_xfer();
    m0_if.rd = 1'b1; m0_if.addr = 12'h0F0;
    step();
    step();
    drive_beats(4, 1'b1, 16'h0400);
    rst = 1'b0;
    sdr_get = 1'b1;
    step();
    @(negedge clk);
    n_tests++;
    if ({sdr_rd, sdr_wr, busy, err, m0_if.get, m0_if.put, m0_if.done, m1_if.get} !== 8'b0 ||
        sdr_addr !== '0 || state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL midrst_outputs: rd%b wr%b busy%b err%b get%b put%b done%b addr=%h state=%0d, want all 0 IDLE",
               sdr_rd, sdr_wr, busy, err, m0_if.get, m0_if.put, m0_if.done, sdr_addr, state);
    end
    rst = 1'b1;
    sdr_get = 1'b0;
    step();
    @(negedge clk);
    n_tests++;
    if (sdr_rd !== 1'b1 || sdr_addr !== 12'h0F0) begin
      n_fail++;
      $display("FAIL midrst_reissue: rd=%b addr=%h, want 1 0f0", sdr_rd, sdr_addr);
    end
    step();
    drive_beats(BL - 1, 1'b1, 16'h0500);
    @(negedge clk);
    n_tests++;
    if (state !== ST_XFER || m0_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_count: state=%0d done=%b after 7 beats, want XFER 0", state, m0_if.done);
    end
    drive_beats(1, 1'b1, 16'h0507);
    @(negedge clk);
    n_tests++;
    if (m0_if.done !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_done: done=%b after 8 beats, want 1", m0_if.done);
    end
    m0_if.rd = 1'b0;
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_m0_read();
    test_m0_write();
    test_collision();
    test_starve();
    test_watchdog();
    test_reset_mid_xfer();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
